uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
8-bit asynchronous serial transmitter, the transmit-side companion to the existing UART receiver. It sends one 8N1-style frame per accepted byte: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. Each bit lasts BIT_CLK clocks. Bytes are taken over a valid/ready handshake from the host-side logic, and new frames are gated by the peer's clear-to-send.

Parameters:
BIT_CLK, 87, clocks per serial bit (clk freq / baud); must be >= 2.
PARITY, 0, 0 = none, 1 = even, 2 = odd; any other value behaves as none.
STOP_BITS, 1, number of stop bits; 1 or 2; any other value behaves as 1.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
txdata  input  8  byte to send; sampled only on handshake.
tx_valid  input  1  host has a byte on txdata.
tx_ready  output  1  transmitter can accept a byte this cycle.
cts  input  1  peer clear-to-send; 1 = transmission permitted (pairs with the receiver's rts).
txd  output  1  serial line; idles high.
busy  output  1  1 while a frame is in progress (START through last STOP).

Behaviour:
- One clock; reset is synchronous and active-low.
- While reset = 0, at every edge: state <= IDLE; txd = 1; busy = 0; tx_ready = 0; counters and shift register cleared.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: txd = 1, busy = 0, tx_ready = cts (and reset = 1).
- Accept: on an edge where tx_valid & tx_ready = 1:
  - latch txdata into the shift register and compute the parity bit from the latched byte;
  - state -> START. From the next cycle: txd = 0, busy = 1, tx_ready = 0.
- START: txd = 0 for exactly BIT_CLK cycles, then -> DATA.
- DATA: 8 bits, LSB first, each held BIT_CLK cycles. A 3-bit index advances when the bit counter reaches BIT_CLK-1. After bit 7 -> PARITY if PARITY is 1 or 2, else -> STOP.
- PARITY: txd = even-parity bit (XOR of the 8 data bits) or its inverse for odd; held BIT_CLK cycles; then -> STOP.
- STOP: txd = 1 for STOP_BITS*BIT_CLK cycles; then -> IDLE.
- Frame length from the first start-bit cycle to the last stop cycle: (9 + P + STOP_BITS)*BIT_CLK cycles, where P = 1 if parity is enabled, else 0.
- tx_ready may rise in the first cycle after the last stop cycle.
- Bit counter: ceil(log2(BIT_CLK)) bits; counts 0..BIT_CLK-1 and wraps to 0 at each bit boundary. No drift across bits.
- txd is driven from a register: glitch-free, no combinational path from inputs.
- Back-to-back: if tx_valid stays high, the next accept happens in the first IDLE cycle (when cts = 1). That gives exactly one idle-high cycle between the last stop cycle and the next start bit.
- cts is sampled only in IDLE. Dropping cts mid-frame does not abort the frame; it only blocks the next accept.
- tx_valid with cts = 0: no accept; txd stays 1; the host holds the data.
- txdata changes after accept have no effect on the frame in flight.
- Reset mid-frame: the frame is aborted and txd = 1 after that edge. After reset is released, the next accepted frame starts from a clean state.

Test Plan:
1. Hold reset = 0 for 5 cycles with tx_valid = 1, cts = 1 -> txd = 1, tx_ready = 0, busy = 0 throughout. After release, tx_ready = 1 in the first cycle.
2. BIT_CLK = 4, PARITY = 0, STOP_BITS = 1; send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); busy high for those 40 cycles; tx_ready returns in cycle 41.
3. BIT_CLK = 4; tx_valid held with 0x00 then 0xFF -> frame 1 data bits all 0, stop bit, one idle cycle at 1, then frame 2 start bit = 0 followed by eight 1s; both bytes accepted with no loss.
4. cts = 0, tx_valid = 1 with 0x3C for 20 cycles -> no accept, txd = 1. Raise cts -> accept on that edge. Drop cts during bit 3 -> frame completes intact.
5. BIT_CLK = 4; PARITY = 1, send 0x07 -> parity bit = 1. PARITY = 2, send 0x07 -> parity bit = 0. STOP_BITS = 2 -> stop high for 8 cycles.
6. Assert reset during data bit 4 of 0x55 -> txd = 1 the next cycle, busy = 0. After release, send 0x81 -> correct full frame with no residue from 0x55.

Source files
------------

// File: rtl/uart_tx_if.sv
// Host/peer-facing signal bundle for the UART transmitter.
// The master side is the host logic plus the peer's flow control;
// the slave side is the transmitter itself.
interface uart_tx_if;
   logic [7:0] txdata;
   logic       tx_valid;
   logic       tx_ready;
   logic       cts;
   logic       txd;
   logic       busy;

   modport master (
      output txdata, tx_valid, cts,
      input  tx_ready, txd, busy
   );

   modport slave (
      input  txdata, tx_valid, cts,
      output tx_ready, txd, busy
   );
endinterface

// File: rtl/uart_tx.sv
// 8-bit asynchronous serial transmitter: start bit, 8 data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits. Each bit lasts BIT_CLK clocks.
//
// state  | meaning
// IDLE   | line high, waiting for a byte while cts = 1
// START  | start bit (0) on the line
// DATA   | data bits, LSB first, indexed by bit_idx
// PARITY | parity bit (only when parity is enabled)
// STOP   | stop bit(s), high; stop_cnt selects first/second stop bit
module uart_tx #(
   parameter int BIT_CLK   = 87,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic      clk,
   input  logic      reset,
   uart_tx_if.slave  bus
);
   localparam int CW = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLK - 1);
   localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
   localparam logic PAR_ODD = (PARITY == 2);
   localparam logic TWO_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY_S = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] bit_cnt, bit_cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic          stop_cnt, stop_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par_bit, par_bit_n;
   logic          txd_q, txd_n;
   logic          last_cnt;
   logic          accept;

   assign last_cnt     = (bit_cnt == CNT_LAST);
   assign bus.tx_ready = (state == IDLE) && bus.cts && reset;
   assign accept       = bus.tx_valid && bus.tx_ready;
   assign bus.busy     = (state != IDLE);
   assign bus.txd      = txd_q;

   // State, counters, shift register and the registered serial line.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         txd_q    <= 1'b1;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         bit_idx  <= bit_idx_n;
         stop_cnt <= stop_cnt_n;
         shreg    <= shreg_n;
         par_bit  <= par_bit_n;
         txd_q    <= txd_n;
      end
   end

   // Next-state, bit timing and next line value (derived from the next state
   // so txd comes straight out of a flop).
   always_comb begin
      state_n    = state;
      bit_cnt_n  = last_cnt ? '0 : bit_cnt + CW'(1);
      bit_idx_n  = bit_idx;
      stop_cnt_n = stop_cnt;
      shreg_n    = shreg;
      par_bit_n  = par_bit;
      txd_n      = 1'b1;

      case (state)
         IDLE: begin
            bit_cnt_n = '0;
            if (accept) begin
               state_n   = START;
               shreg_n   = bus.txdata;
               par_bit_n = (^bus.txdata) ^ PAR_ODD;
            end
         end
         START: begin
            if (last_cnt) begin
               state_n   = DATA;
               bit_idx_n = '0;
            end
         end
         DATA: begin
            if (last_cnt) begin
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_n    = PAR_EN ? PARITY_S : STOP;
                  stop_cnt_n = 1'b0;
               end
            end
         end
         PARITY_S: begin
            if (last_cnt) begin
               state_n    = STOP;
               stop_cnt_n = 1'b0;
            end
         end
         STOP: begin
            if (last_cnt) begin
               if (TWO_STOP && !stop_cnt) stop_cnt_n = 1'b1;
               else                       state_n    = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      case (state_n)
         START:    txd_n = 1'b0;
         DATA:     txd_n = shreg_n[bit_idx_n];
         PARITY_S: txd_n = par_bit_n;
         default:  txd_n = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances with BIT_CLK = 4
//   unit 0: no parity, 1 stop; unit 1: even parity, 1 stop; unit 2: odd parity, 2 stops.
module tb_uart_tx;
   localparam int BC = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] txdata = 8'h00;
   logic       cts = 1'b1;
   logic [2:0] valid = 3'b000;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_if if0 ();
   uart_tx_if if1 ();
   uart_tx_if if2 ();

   assign if0.txdata = txdata; assign if0.tx_valid = valid[0]; assign if0.cts = cts;
   assign if1.txdata = txdata; assign if1.tx_valid = valid[1]; assign if1.cts = cts;
   assign if2.txdata = txdata; assign if2.tx_valid = valid[2]; assign if2.cts = cts;

   uart_tx #(.BIT_CLK(BC), .PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
   uart_tx #(.BIT_CLK(BC), .PARITY(1), .STOP_BITS(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
   uart_tx #(.BIT_CLK(BC), .PARITY(2), .STOP_BITS(2)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

   typedef struct {
      int         u;
      logic [7:0] data;
      logic       par;   // hand-computed parity bit (ignored for unit 0)
   } vec_t;

   function automatic logic get_txd(int u);
      case (u)
         0: return if0.txd;
         1: return if1.txd;
         default: return if2.txd;
      endcase
   endfunction

   function automatic logic get_ready(int u);
      case (u)
         0: return if0.tx_ready;
         1: return if1.tx_ready;
         default: return if2.tx_ready;
      endcase
   endfunction

   function automatic logic get_busy(int u);
      case (u)
         0: return if0.busy;
         1: return if1.busy;
         default: return if2.busy;
      endcase
   endfunction

   function automatic int frame_bits(int u);
      case (u)
         0: return 10;
         1: return 11;
         default: return 12;
      endcase
   endfunction

   function automatic logic exp_bit(int u, logic [7:0] d, logic par, int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (b == 9 && u != 0) return par;
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present a byte and return just after the accepting edge.
   task automatic send_start(input int u, input logic [7:0] d, input bit keep);
      int n;
      valid[u] = 1'b1;
      txdata   = d;
      @(negedge clk);
      n = 0;
      while (!get_ready(u) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check("accept_timeout", 32'd1, 32'd0);
         valid[u] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (!keep) valid[u] = 1'b0;
      txdata = ~d;
   endtask

   // Check every cycle of a frame, then the first idle cycle after it.
   task automatic check_frame(input int u, input logic [7:0] d, input logic par, input int drop_cts_bit);
      int nb;
      logic bad_txd, bad_busy;
      nb = frame_bits(u);
      for (int b = 0; b < nb; b++) begin
         bad_txd = 1'b0;
         bad_busy = 1'b0;
         for (int c = 0; c < BC; c++) begin
            @(negedge clk);
            if (get_txd(u) !== exp_bit(u, d, par, b)) bad_txd = 1'b1;
            if (get_busy(u) !== 1'b1) bad_busy = 1'b1;
            if (b == drop_cts_bit && c == 0) cts = 1'b0;
         end
         check($sformatf("u%0d_d%02h_bit%0d_txd", u, d, b), {31'd0, bad_txd}, 32'd0);
         check($sformatf("u%0d_d%02h_bit%0d_busy", u, d, b), {31'd0, bad_busy}, 32'd0);
      end
      @(negedge clk);
      check("idle_txd", {31'd0, get_txd(u)}, 32'd1);
      check("idle_busy", {31'd0, get_busy(u)}, 32'd0);
      check("idle_ready", {31'd0, get_ready(u)}, {31'd0, cts});
   endtask

   vec_t vecs[$];

   initial begin
      vecs.push_back('{u: 0, data: 8'hA5, par: 1'b0});
      vecs.push_back('{u: 0, data: 8'h3C, par: 1'b0});
      vecs.push_back('{u: 1, data: 8'h07, par: 1'b1});
      vecs.push_back('{u: 1, data: 8'h03, par: 1'b0});
      vecs.push_back('{u: 2, data: 8'h07, par: 1'b0});
      vecs.push_back('{u: 2, data: 8'h00, par: 1'b1});
      vecs.push_back('{u: 2, data: 8'hA5, par: 1'b1});

      // Reset held with valid high: nothing leaves the transmitters.
      reset = 1'b0;
      cts   = 1'b1;
      valid = 3'b111;
      txdata = 8'h5A;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         for (int u = 0; u < 3; u++) begin
            check("rst_txd",   {31'd0, get_txd(u)},   32'd1);
            check("rst_ready", {31'd0, get_ready(u)}, 32'd0);
            check("rst_busy",  {31'd0, get_busy(u)},  32'd0);
         end
      end
      @(posedge clk);
      #1;
      valid = 3'b000;
      reset = 1'b1;
      @(negedge clk);
      for (int u = 0; u < 3; u++) check("post_rst_ready", {31'd0, get_ready(u)}, 32'd1);

      // Table-driven frames across the three configurations.
      for (int i = 0; i < vecs.size(); i++) begin
         send_start(vecs[i].u, vecs[i].data, 1'b0);
         check_frame(vecs[i].u, vecs[i].data, vecs[i].par, -1);
      end

      // Back-to-back: valid held, one idle cycle between frames.
      send_start(0, 8'h00, 1'b1);
      txdata = 8'hFF;
      check_frame(0, 8'h00, 1'b0, -1);
      @(posedge clk);
      #1;
      valid[0] = 1'b0;
      check_frame(0, 8'hFF, 1'b0, -1);

      // cts low blocks the accept; dropping it mid-frame does not abort.
      cts = 1'b0;
      valid[0] = 1'b1;
      txdata = 8'h3C;
      begin
         logic bad;
         bad = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if0.txd !== 1'b1 || if0.tx_ready !== 1'b0 || if0.busy !== 1'b0) bad = 1'b1;
         end
         check("cts_low_blocked", {31'd0, bad}, 32'd0);
      end
      @(posedge clk);
      #1;
      cts = 1'b1;
      @(posedge clk);
      #1;
      valid[0] = 1'b0;
      txdata = 8'h00;
      check_frame(0, 8'h3C, 1'b0, 4);
      check("cts_dropped_ready", {31'd0, if0.tx_ready}, 32'd0);
      cts = 1'b1;

      // Reset during data bit 4 aborts the frame cleanly.
      send_start(0, 8'h55, 1'b0);
      repeat (BC + 4 * BC + 2) @(negedge clk);
      check("pre_abort_busy", {31'd0, if0.busy}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      check("abort_txd",  {31'd0, if0.txd},  32'd1);
      check("abort_busy", {31'd0, if0.busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_release_ready", {31'd0, if0.tx_ready}, 32'd1);
      send_start(0, 8'h81, 1'b0);
      check_frame(0, 8'h81, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
